// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports and two write
// ports. It also holds a per-register busy scoreboard and a sequencer that
// zeroes the whole file one register per cycle on request.
module regfile_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              busy1_o,
    output logic              busy2_o,
    input  logic              clr_req_i,
    output logic              ready_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    logic              wr0_act_s;
    logic              wr1_act_s;
    logic              rsv_act_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // True when the address is the hardwired-zero register.
    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG_EN != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    // Write/reserve requests only take effect while idle and never target the zero register.
    assign wr0_act_s = (state_q == ST_IDLE) && wr0_en_i && !is_zero_addr(wr0_addr_i);
    assign wr1_act_s = (state_q == ST_IDLE) && wr1_en_i && !is_zero_addr(wr1_addr_i);
    assign rsv_act_s = (state_q == ST_IDLE) && rsv_en_i && !is_zero_addr(rsv_addr_i);

    // Next contents of the array and scoreboard: clear walk, else writes then reserve.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (state_q == ST_CLEAR) begin
            regs_d[cnt_q] = {DATA_W{1'b0}};
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (wr0_act_s) begin
                regs_d[wr0_addr_i] = wr0_data_i;
                busy_d[wr0_addr_i] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            // Port 1 is applied last so it wins an address collision.
            if (wr1_act_s) begin
                regs_d[wr1_addr_i] = wr1_data_i;
                busy_d[wr1_addr_i] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            // A reserve marks a newer producer, so it overrides a same-cycle write clear.
            if (rsv_act_s) begin
                busy_d[rsv_addr_i] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
    end

    // Array and scoreboard storage, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Clear sequencer: visits every register once, holding ready low meanwhile.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= {ADDR_W{1'b0}};
                        ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= {ADDR_W{1'b0}};
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {ADDR_W{1'b0}};
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Read port 1: zero register, then same-cycle forwarding (port 1 first), then storage.
    always_comb begin
        rd1_s = regs_q[rd_addr1_i];
        if (is_zero_addr(rd_addr1_i)) begin
            rd1_s = {DATA_W{1'b0}};
        end else if ((BYPASS_EN != 0) && wr1_act_s && (wr1_addr_i == rd_addr1_i)) begin
            rd1_s = wr1_data_i;
        end else if ((BYPASS_EN != 0) && wr0_act_s && (wr0_addr_i == rd_addr1_i)) begin
            rd1_s = wr0_data_i;
        end else begin
            rd1_s = regs_q[rd_addr1_i];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rd2_s = regs_q[rd_addr2_i];
        if (is_zero_addr(rd_addr2_i)) begin
            rd2_s = {DATA_W{1'b0}};
        end else if ((BYPASS_EN != 0) && wr1_act_s && (wr1_addr_i == rd_addr2_i)) begin
            rd2_s = wr1_data_i;
        end else if ((BYPASS_EN != 0) && wr0_act_s && (wr0_addr_i == rd_addr2_i)) begin
            rd2_s = wr0_data_i;
        end else begin
            rd2_s = regs_q[rd_addr2_i];
        end
    end

    assign rd_data1_o = rd1_s;
    assign rd_data2_o = rd2_s;
    assign busy1_o    = busy_q[rd_addr1_i] && !is_zero_addr(rd_addr1_i);
    assign busy2_o    = busy_q[rd_addr2_i] && !is_zero_addr(rd_addr2_i);
    assign ready_o    = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table, clear/reset sequences, a
// small-geometry instance, and random traffic against a behavioural model.
module tb_regfile_param;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  rd_addr1_i, rd_addr2_i, wr0_addr_i, wr1_addr_i, rsv_addr_i;
    logic [31:0] rd_data1_o, rd_data2_o, wr0_data_i, wr1_data_i;
    logic        wr0_en_i, wr1_en_i, rsv_en_i, clr_req_i;
    logic        busy1_o, busy2_o, ready_o;

    logic [2:0]  s_rd_addr1, s_rd_addr2, s_wr0_addr, s_wr1_addr, s_rsv_addr;
    logic [7:0]  s_rd_data1, s_rd_data2, s_wr0_data, s_wr1_data;
    logic        s_wr0_en, s_wr1_en, s_rsv_en, s_clr_req;
    logic        s_busy1, s_busy2, s_ready;

    int n_vec = 0;
    int n_err = 0;

    regfile_param dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr1_i(rd_addr1_i), .rd_addr2_i(rd_addr2_i),
        .rd_data1_o(rd_data1_o), .rd_data2_o(rd_data2_o),
        .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
        .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i),
        .busy1_o(busy1_o), .busy2_o(busy2_o),
        .clr_req_i(clr_req_i), .ready_o(ready_o)
    );

    regfile_param #(.DATA_W(8), .ADDR_W(3)) u_small (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr1_i(s_rd_addr1), .rd_addr2_i(s_rd_addr2),
        .rd_data1_o(s_rd_data1), .rd_data2_o(s_rd_data2),
        .wr0_en_i(s_wr0_en), .wr0_addr_i(s_wr0_addr), .wr0_data_i(s_wr0_data),
        .wr1_en_i(s_wr1_en), .wr1_addr_i(s_wr1_addr), .wr1_data_i(s_wr1_data),
        .rsv_en_i(s_rsv_en), .rsv_addr_i(s_rsv_addr),
        .busy1_o(s_busy1), .busy2_o(s_busy2),
        .clr_req_i(s_clr_req), .ready_o(s_ready)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        w0en; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1en; logic [4:0] w1a; logic [31:0] w1d;
        logic        rsv;  logic [4:0] rsva;
        logic        clr;  logic [4:0] ra1; logic [4:0] ra2;
    } vin_t;

    typedef struct {
        vin_t        v;
        logic [31:0] e_rd1;
        logic        e_busy1;
        logic        e_ready;
    } tvec_t;

    // Behavioural model: plain register contents, busy flags, clear cycles remaining.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_clr_left;
    int          m_clr_idx;
    vin_t        cur;

    function automatic vin_t mk(input logic w0en, input int w0a, input logic [31:0] w0d,
                                input logic w1en, input int w1a, input logic [31:0] w1d,
                                input logic rsv, input int rsva, input logic clr,
                                input int ra1, input int ra2);
        vin_t v;
        v.w0en = w0en; v.w0a = 5'(w0a); v.w0d = w0d;
        v.w1en = w1en; v.w1a = 5'(w1a); v.w1d = w1d;
        v.rsv = rsv; v.rsva = 5'(rsva); v.clr = clr;
        v.ra1 = 5'(ra1); v.ra2 = 5'(ra2);
        return v;
    endfunction

    function automatic vin_t idle_rd(input int ra1, input int ra2);
        return mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, ra1, ra2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_idx = 0;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (m_clr_left == 0 && cur.w1en && cur.w1a == a) return cur.w1d;
        if (m_clr_left == 0 && cur.w0en && cur.w0a == a) return cur.w0d;
        return m_mem[a];
    endfunction

    function automatic logic m_bz(input logic [4:0] a);
        return (a == 5'd0) ? 1'b0 : m_busy[a];
    endfunction

    task automatic m_update();
        if (m_clr_left > 0) begin
            m_mem[m_clr_idx] = 32'h0;
            m_busy[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (cur.w0en && cur.w0a != 5'd0) begin m_mem[cur.w0a] = cur.w0d; m_busy[cur.w0a] = 1'b0; end
            if (cur.w1en && cur.w1a != 5'd0) begin m_mem[cur.w1a] = cur.w1d; m_busy[cur.w1a] = 1'b0; end
            if (cur.rsv && cur.rsva != 5'd0) m_busy[cur.rsva] = 1'b1;
            if (cur.clr) begin m_clr_left = 32; m_clr_idx = 0; end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a vector, then compare every output of the wide instance with the model.
    task automatic apply(input vin_t v);
        cur = v;
        wr0_en_i = v.w0en; wr0_addr_i = v.w0a; wr0_data_i = v.w0d;
        wr1_en_i = v.w1en; wr1_addr_i = v.w1a; wr1_data_i = v.w1d;
        rsv_en_i = v.rsv;  rsv_addr_i = v.rsva; clr_req_i = v.clr;
        rd_addr1_i = v.ra1; rd_addr2_i = v.ra2;
        #1;
        check("model_rd1", rd_data1_o, m_rd(v.ra1));
        check("model_rd2", rd_data2_o, m_rd(v.ra2));
        check("model_busy1", 32'(busy1_o), 32'(m_bz(v.ra1)));
        check("model_busy2", 32'(busy2_o), 32'(m_bz(v.ra2)));
        check("model_ready", 32'(ready_o), 32'(m_clr_left == 0));
    endtask

    task automatic advance();
        @(posedge clk_i);
        m_update();
        @(negedge clk_i);
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    tvec_t tv [14];
    int    ready_low;

    initial begin
        tv[0]  = '{mk(1'b1, 3, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 3, 3), 32'hDEADBEEF, 1'b0, 1'b1};
        tv[1]  = '{idle_rd(3, 0), 32'hDEADBEEF, 1'b0, 1'b1};
        tv[2]  = '{mk(1'b1, 7, 32'h11, 1'b1, 7, 32'h22, 1'b0, 0, 1'b0, 7, 3), 32'h22, 1'b0, 1'b1};
        tv[3]  = '{idle_rd(7, 3), 32'h22, 1'b0, 1'b1};
        tv[4]  = '{mk(1'b1, 0, 32'h55, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 0, 7), 32'h0, 1'b0, 1'b1};
        tv[5]  = '{idle_rd(0, 7), 32'h0, 1'b0, 1'b1};
        tv[6]  = '{mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9, 1'b0, 9, 0), 32'h0, 1'b0, 1'b1};
        tv[7]  = '{idle_rd(9, 0), 32'h0, 1'b1, 1'b1};
        tv[8]  = '{mk(1'b1, 9, 32'h99, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 9, 0), 32'h99, 1'b1, 1'b1};
        tv[9]  = '{idle_rd(9, 0), 32'h99, 1'b0, 1'b1};
        tv[10] = '{mk(1'b0, 0, 32'h0, 1'b1, 9, 32'hAA, 1'b1, 9, 1'b0, 9, 0), 32'hAA, 1'b0, 1'b1};
        tv[11] = '{idle_rd(9, 0), 32'hAA, 1'b1, 1'b1};
        tv[12] = '{mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 0, 1'b0, 0, 9), 32'h0, 1'b0, 1'b1};
        tv[13] = '{idle_rd(0, 9), 32'h0, 1'b0, 1'b1};

        s_rd_addr1 = 3'd0; s_rd_addr2 = 3'd0; s_wr0_addr = 3'd0; s_wr1_addr = 3'd0;
        s_rsv_addr = 3'd0; s_wr0_data = 8'h0; s_wr1_data = 8'h0;
        s_wr0_en = 1'b0; s_wr1_en = 1'b0; s_rsv_en = 1'b0; s_clr_req = 1'b0;
        cur = idle_rd(5, 9);
        wr0_en_i = 1'b0; wr0_addr_i = 5'd0; wr0_data_i = 32'h0;
        wr1_en_i = 1'b0; wr1_addr_i = 5'd0; wr1_data_i = 32'h0;
        rsv_en_i = 1'b0; rsv_addr_i = 5'd0; clr_req_i = 1'b0;
        rd_addr1_i = 5'd5; rd_addr2_i = 5'd9;

        // Reset state.
        #1 rst_i = 1'b1;
        #2;
        check("rst_rd1", rd_data1_o, 32'h0);
        check("rst_busy1", 32'(busy1_o), 32'h0);
        check("rst_ready", 32'(ready_o), 32'h1);
        check("rst_small_ready", 32'(s_ready), 32'h1);
        m_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed table: bypass, port priority, zero register, scoreboard.
        for (int i = 0; i < 14; i++) begin
            apply(tv[i].v);
            check($sformatf("tab%0d_rd1", i), rd_data1_o, tv[i].e_rd1);
            check($sformatf("tab%0d_busy1", i), 32'(busy1_o), 32'(tv[i].e_busy1));
            check($sformatf("tab%0d_ready", i), 32'(ready_o), 32'(tv[i].e_ready));
            advance();
        end

        // Fill and reserve every register, then a full clear with ignored traffic.
        for (int a = 1; a < 32; a++) begin
            apply(mk(1'b1, a, 32'h1000_0000 + 32'(a), 1'b0, 0, 32'h0, 1'b1, a, 1'b0, a, 32 - a));
            advance();
        end
        apply(mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b1, 4, 5));
        advance();
        ready_low = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 32)
                apply(mk(1'b1, $urandom_range(1, 31), $urandom, 1'b1, $urandom_range(1, 31), $urandom,
                         1'b1, $urandom_range(1, 31), 1'b1, $urandom_range(0, 31), $urandom_range(0, 31)));
            else
                apply(idle_rd(1, 2));
            if (ready_o) break;
            ready_low++;
            advance();
        end
        check("clear_len32", 32'(ready_low), 32'd32);
        for (int a = 0; a < 32; a++) begin
            apply(idle_rd(a, 31 - a));
            check($sformatf("post_clr_rd%0d", a), rd_data1_o, 32'h0);
            check($sformatf("post_clr_busy%0d", a), 32'(busy1_o), 32'h0);
            advance();
        end

        // Reset in the middle of a clear.
        for (int a = 1; a < 32; a++) begin
            apply(mk(1'b1, a, 32'hA500_0000 + 32'(a), 1'b0, 0, 32'h0, 1'b1, a, 1'b0, a, 0));
            advance();
        end
        apply(mk(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b1, 20, 21));
        advance();
        for (int c = 0; c < 10; c++) begin
            apply(idle_rd(20, 21));
            advance();
        end
        check("pre_rst_rd20", rd_data1_o, 32'hA500_0014);
        rst_i = 1'b1;
        #1;
        check("midclr_rst_ready", 32'(ready_o), 32'h1);
        for (int a = 0; a < 32; a++) begin
            rd_addr1_i = 5'(a);
            #1;
            check($sformatf("midclr_rst_rd%0d", a), rd_data1_o, 32'h0);
            check($sformatf("midclr_rst_busy%0d", a), 32'(busy1_o), 32'h0);
        end
        m_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        apply(mk(1'b1, 5, 32'h1234_5678, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 5, 0));
        advance();
        apply(idle_rd(5, 0));
        check("post_rst_write", rd_data1_o, 32'h1234_5678);
        advance();

        // Small geometry: 8-register file clears in 8 cycles.
        s_wr0_en = 1'b1; s_wr0_addr = 3'd5; s_wr0_data = 8'hA5; s_rd_addr1 = 3'd5;
        @(posedge clk_i); @(negedge clk_i);
        s_wr0_en = 1'b0;
        #1 check("small_wr", 32'(s_rd_data1), 32'hA5);
        s_clr_req = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        s_clr_req = 1'b0;
        ready_low = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (s_ready) break;
            ready_low++;
            @(posedge clk_i); @(negedge clk_i);
        end
        check("small_clear_len8", 32'(ready_low), 32'd8);
        check("small_cleared", 32'(s_rd_data1), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            vin_t v;
            v = mk($urandom_range(0, 1), rnd_addr(), $urandom, $urandom_range(0, 1), rnd_addr(), $urandom,
                   $urandom_range(0, 1), rnd_addr(), ($urandom_range(0, 59) == 0), rnd_addr(), rnd_addr());
            apply(v);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG_EN, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL have parameter BYPASS_EN, default 1, write-to-read forwarding in the same cycle when 1.
REQ-005 SHALL have port clk_i  input  1  clock; all state changes on the posedge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_addr1_i  input  ADDR_W  read port 1 address.
REQ-008 SHALL have port rd_addr2_i  input  ADDR_W  read port 2 address.
REQ-009 SHALL have port rd_data1_o  output  DATA_W  read port 1 data.
REQ-010 SHALL have port rd_data2_o  output  DATA_W  read port 2 data.
REQ-011 SHALL have port wr0_en_i  input  1  write port 0 enable.
REQ-012 SHALL have port wr0_addr_i  input  ADDR_W  write port 0 address.
REQ-013 SHALL have port wr0_data_i  input  DATA_W  write port 0 data.
REQ-014 SHALL have port wr1_en_i  input  1  write port 1 enable.
REQ-015 SHALL have port wr1_addr_i  input  ADDR_W  write port 1 address.
REQ-016 SHALL have port wr1_data_i  input  DATA_W  write port 1 data.
REQ-017 SHALL have port rsv_en_i  input  1  scoreboard reserve enable (marks a register as pending).
REQ-018 SHALL have port rsv_addr_i  input  ADDR_W  register to reserve.
REQ-019 SHALL have port busy1_o  output  1  pending flag of rd_addr1_i.
REQ-020 SHALL have port busy2_o  output  1  pending flag of rd_addr2_i.
REQ-021 SHALL have port clr_req_i  input  1  request a sequential clear of the whole file.
REQ-022 SHALL have port ready_o  output  1  high when idle and accepting writes/reserves/clear requests.

Function
REQ-023 Reads SHALL be combinational from the array, zero-latency.
REQ-024 With BYPASS_EN=1 and state IDLE, a read address matching an enabled write address in the same cycle SHALL return that write data; if both write ports match, wr1 data.
REQ-025 Writes SHALL update the array at the posedge; both ports to the same address SHALL store wr1_data_i (port 1 priority).
REQ-026 With ZERO_REG_EN=1, address 0 SHALL read 0, ignore writes and reserves, never forward, and report busy 0.
REQ-027 Scoreboard SHALL hold one busy bit per register: rsv_en_i sets busy[rsv_addr_i]; any enabled write clears busy[wr addr] at the posedge.
REQ-028 Reserve and write to the same address in one cycle SHALL leave busy set (reserve wins: newer producer).
REQ-029 busy1_o/busy2_o SHALL be combinational from the stored busy bits (no bypass of same-cycle write/reserve).
REQ-030 A clear FSM SHALL have states IDLE and CLEAR with an ADDR_W-bit counter.
REQ-031 IDLE -> CLEAR when clr_req_i=1; counter SHALL start at 0.
REQ-032 In CLEAR, each cycle SHALL write 0 to register[counter], clear busy[counter], increment counter; at counter = DEPTH-1 SHALL return to IDLE; clear lasts exactly DEPTH cycles.
REQ-033 ready_o SHALL be 1 in IDLE, 0 in CLEAR (registered from state).
REQ-034 In CLEAR, write enables, rsv_en_i and clr_req_i SHALL be ignored; reads SHALL return stored array contents without forwarding.

Reset
REQ-035 rst_i=1 SHALL immediately clear all registers and busy bits to 0, set state IDLE, counter 0, ready_o 1, including mid-CLEAR.
REQ-036 After reset release, the first posedge SHALL accept writes normally.

Verification
REQ-037 Defaults; wr0 addr 3 data 0xDEADBEEF, rd_addr1=3 same cycle -> rd_data1_o=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-038 wr0 addr 7 data 0x11, wr1 addr 7 data 0x22 same cycle -> register 7 reads 0x22; write addr 0 data 0x55 -> reads 0.
REQ-039 rsv addr 9 -> busy1_o=1 for rd_addr1=9 next cycle; write 9 -> busy 0 next cycle; reserve+write 9 same cycle -> busy stays 1.
REQ-040 Fill registers 1..31 with nonzero, pulse clr_req_i -> ready_o 0 for exactly 32 cycles, writes ignored, then all reads 0 and ready_o 1.
REQ-041 Assert rst_i at clear cycle 10 -> all registers 0, ready_o 1 immediately; DATA_W=8, ADDR_W=3 instance clear lasts 8 cycles.
